// File: rtl/exec_seq_pkg.sv
// exec_seq_pkg: shared state/class enums, LEGv8 opcode patterns and ALU control encodings.
// Used by exec_sequencer and exec_seq_decode.
package exec_seq_pkg;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_ILLEGAL} class_t;

    localparam logic [1:0] SRC_REG   = 2'b00;
    localparam logic [1:0] SRC_SEXT  = 2'b01;
    localparam logic [1:0] SRC_IMM12 = 2'b10;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_BR   = 2'b01;
    localparam logic [1:0] OP_FUNC = 2'b10;

    localparam logic [10:0] OPC_ADD  = 11'h458;
    localparam logic [10:0] OPC_SUB  = 11'h658;
    localparam logic [10:0] OPC_AND  = 11'h450;
    localparam logic [10:0] OPC_ORR  = 11'h550;
    localparam logic [10:0] OPC_LDUR = 11'h7C2;
    localparam logic [10:0] OPC_STUR = 11'h7C0;

    // Ranged opcodes: low bits of the field belong to the immediate/offset.
    localparam logic [10:0] OPC_ADDI = 11'h488, MSK_ADDI = 11'h7FE;
    localparam logic [10:0] OPC_SUBI = 11'h688, MSK_SUBI = 11'h7FE;
    localparam logic [10:0] OPC_MOVZ = 11'h694, MSK_MOVZ = 11'h7FC;
    localparam logic [10:0] OPC_B    = 11'h0A0, MSK_B    = 11'h7E0;
    localparam logic [10:0] OPC_CBZ  = 11'h5A0, MSK_CBZ  = 11'h7F8;
    localparam logic [10:0] OPC_CBNZ = 11'h5A8, MSK_CBNZ = 11'h7F8;

    function automatic logic opc_match(logic [10:0] opc, logic [10:0] val, logic [10:0] msk);
        return (opc & msk) == val;
    endfunction

endpackage

// File: rtl/exec_seq_decode.sv
// exec_seq_decode: combinational opcode classifier producing instruction class and ALU/branch controls.
module exec_seq_decode
    import exec_seq_pkg::*;
(
    input  logic [10:0] opc_i,
    output class_t      cls_o,
    output logic [1:0]  alu_src_o,
    output logic [1:0]  alu_op_o,
    output logic        b_o,
    output logic        bz_o,
    output logic        bnz_o,
    output logic        legal_o
);

    always_comb begin
        cls_o     = C_ILLEGAL;
        alu_src_o = SRC_REG;
        alu_op_o  = OP_ADD;
        b_o       = 1'b0;
        bz_o      = 1'b0;
        bnz_o     = 1'b0;
        if (opc_i == OPC_ADD || opc_i == OPC_SUB || opc_i == OPC_AND || opc_i == OPC_ORR) begin
            cls_o    = C_ALU;
            alu_op_o = OP_FUNC;
        end else if (opc_match(opc_i, OPC_ADDI, MSK_ADDI) || opc_match(opc_i, OPC_SUBI, MSK_SUBI)) begin
            cls_o     = C_ALU;
            alu_src_o = SRC_IMM12;
            alu_op_o  = OP_FUNC;
        end else if (opc_match(opc_i, OPC_MOVZ, MSK_MOVZ)) begin
            cls_o     = C_ALU;
            alu_src_o = SRC_SEXT;
            alu_op_o  = OP_FUNC;
        end else if (opc_i == OPC_LDUR) begin
            cls_o     = C_LOAD;
            alu_src_o = SRC_SEXT;
        end else if (opc_i == OPC_STUR) begin
            cls_o     = C_STORE;
            alu_src_o = SRC_SEXT;
        end else if (opc_match(opc_i, OPC_B, MSK_B)) begin
            cls_o    = C_BRANCH;
            alu_op_o = OP_BR;
            b_o      = 1'b1;
        end else if (opc_match(opc_i, OPC_CBZ, MSK_CBZ)) begin
            cls_o    = C_BRANCH;
            alu_op_o = OP_BR;
            bz_o     = 1'b1;
        end else if (opc_match(opc_i, OPC_CBNZ, MSK_CBNZ)) begin
            cls_o    = C_BRANCH;
            alu_op_o = OP_BR;
            bnz_o    = 1'b1;
        end
        legal_o = cls_o != C_ILLEGAL;
    end

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle LEGv8 control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define EXEC_SEQ_PERF_EN to add cycle_cnt/retired_cnt performance counters.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int OPC_W = 11
`ifdef EXEC_SEQ_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef EXEC_SEQ_PERF_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt,
`endif
    input  logic [31:0] instr_in,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        zero,
    output logic        imem_req,
    output logic        ir_write,
    output logic [31:0] instr_q,
    output logic [1:0]  alu_src,
    output logic [1:0]  alu_op,
    output logic        b,
    output logic        bz,
    output logic        bnz,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        illegal
);

    state_t     state_q;
    class_t     cls_q, dec_cls;
    logic [1:0] alu_src_q, alu_op_q, dec_alu_src, dec_alu_op;
    logic       b_q, bz_q, bnz_q, illegal_q;
    logic       dec_b, dec_bz, dec_bnz, dec_legal;

    exec_seq_decode u_dec (
        .opc_i     (instr_q[31 -: OPC_W]),
        .cls_o     (dec_cls),
        .alu_src_o (dec_alu_src),
        .alu_op_o  (dec_alu_op),
        .b_o       (dec_b),
        .bz_o      (dec_bz),
        .bnz_o     (dec_bnz),
        .legal_o   (dec_legal)
    );

    // Strobes decode from the registered state so an async reset drops them without a clock edge.
    assign imem_req   = state_q == S_FETCH;
    assign ir_write   = imem_req & imem_ready;
    assign mem_read   = state_q == S_MEM && cls_q == C_LOAD;
    assign mem_write  = state_q == S_MEM && cls_q == C_STORE;
    assign reg_write  = state_q == S_WB;
    assign mem_to_reg = reg_write && cls_q == C_LOAD;
    assign pc_write   = (state_q == S_EXEC && cls_q == C_BRANCH) || (mem_write && dmem_ready) || reg_write;
    assign pc_src     = state_q == S_EXEC && (b_q || (bz_q && zero) || (bnz_q && !zero));
    assign alu_src    = alu_src_q;
    assign alu_op     = alu_op_q;
    assign b          = b_q;
    assign bz         = bz_q;
    assign bnz        = bnz_q;
    assign illegal    = illegal_q;

    // Every return to FETCH coincides with pc_write, which also clears the held controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cls_q     <= C_ILLEGAL;
            instr_q   <= '0;
            alu_src_q <= SRC_REG;
            alu_op_q  <= OP_ADD;
            b_q       <= 1'b0;
            bz_q      <= 1'b0;
            bnz_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else if (pc_write) begin
            state_q   <= S_FETCH;
            alu_src_q <= SRC_REG;
            alu_op_q  <= OP_ADD;
            b_q       <= 1'b0;
            bz_q      <= 1'b0;
            bnz_q     <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: if (imem_ready) begin
                    instr_q <= instr_in;
                    state_q <= S_DECODE;
                end
                S_DECODE: if (dec_legal) begin
                    state_q   <= S_EXEC;
                    cls_q     <= dec_cls;
                    alu_src_q <= dec_alu_src;
                    alu_op_q  <= dec_alu_op;
                    b_q       <= dec_b;
                    bz_q      <= dec_bz;
                    bnz_q     <= dec_bnz;
                end else begin
                    state_q   <= S_TRAP;
                    illegal_q <= 1'b1;
                end
                S_EXEC:  state_q <= cls_q == C_ALU ? S_WB : S_MEM;
                S_MEM:   if (dmem_ready) state_q <= S_WB;
                default: ;
            endcase
        end
    end

`ifdef EXEC_SEQ_PERF_EN
    logic [CNT_W-1:0] cycle_q, retired_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            if (state_q != S_TRAP) cycle_q <= cycle_q + CNT_W'(1);
            if (pc_write) retired_q <= retired_q + CNT_W'(1);
        end
    end
    assign cycle_cnt   = cycle_q;
    assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed cycle-by-cycle checks of exec_sequencer control outputs.
// Output vector order: {imem_req,ir_write}_{alu_src}_{alu_op}_{b,bz,bnz}_{mem_read,mem_write,mem_to_reg,reg_write}_{pc_write,pc_src}_{illegal}
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_in;
    logic        imem_ready, dmem_ready, zero;
    logic        imem_req, ir_write, b, bz, bnz;
    logic        mem_read, mem_write, mem_to_reg, reg_write, pc_write, pc_src, illegal;
    logic [31:0] instr_q;
    logic [1:0]  alu_src, alu_op;
    logic [15:0] vec;
`ifdef EXEC_SEQ_PERF_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [31:0] I_ADD  = 32'h8B020020;
    localparam logic [31:0] I_LDUR = 32'hF8400020;
    localparam logic [31:0] I_STUR = 32'hF8000020;
    localparam logic [31:0] I_CBZ  = 32'hB4000000;
    localparam logic [31:0] I_CBNZ = 32'hB5E00000;
    localparam logic [31:0] I_B    = 32'h14A00000;
    localparam logic [31:0] I_ADDI = 32'h91200000;
    localparam logic [31:0] I_MOVZ = 32'hD2E00000;
    localparam logic [31:0] I_BAD  = 32'h00000000;

    localparam logic [15:0] V_IDLE = 16'b10_00_00_000_0000_00_0;
    localparam logic [15:0] V_LOAD = 16'b11_00_00_000_0000_00_0;
    localparam logic [15:0] V_NONE = 16'b00_00_00_000_0000_00_0;

    always #5 clk = ~clk;

    exec_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef EXEC_SEQ_PERF_EN
        .cycle_cnt  (cycle_cnt),
        .retired_cnt(retired_cnt),
`endif
        .instr_in   (instr_in),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .zero       (zero),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .instr_q    (instr_q),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .b          (b),
        .bz         (bz),
        .bnz        (bnz),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .illegal    (illegal)
    );

    assign vec = {imem_req, ir_write, alu_src, alu_op, b, bz, bnz,
                  mem_read, mem_write, mem_to_reg, reg_write, pc_write, pc_src, illegal};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance past the next edge.
    task automatic cyc(input string tag, input logic [31:0] ins, input logic ir, input logic dr,
                       input logic z, input logic [15:0] exp);
        instr_in = ins;
        imem_ready = ir;
        dmem_ready = dr;
        zero = z;
        #1;
        chk(tag, {16'h0, vec}, {16'h0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        instr_in = '0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_vec", {16'h0, vec}, {16'h0, V_IDLE});
        chk("reset_ir", instr_q, 32'h0);
        rst_n = 1'b1;

        cyc("add_fetch", I_ADD, 1, 0, 0, V_LOAD);
        cyc("add_decode", 0, 0, 0, 0, V_NONE);
        cyc("add_exec", 0, 0, 0, 0, 16'b00_00_10_000_0000_00_0);
        chk("add_ir", instr_q, I_ADD);
        cyc("add_wb", 0, 0, 0, 0, 16'b00_00_10_000_0001_10_0);

        cyc("ld_imem_wait", I_LDUR, 0, 0, 0, V_IDLE);
        cyc("ld_fetch", I_LDUR, 1, 0, 0, V_LOAD);
        cyc("ld_decode", 0, 0, 1, 0, V_NONE);
        cyc("ld_exec", 0, 0, 0, 0, 16'b00_01_00_000_0000_00_0);
        cyc("ld_mem1", 0, 0, 0, 0, 16'b00_01_00_000_1000_00_0);
        cyc("ld_mem2", 0, 0, 0, 0, 16'b00_01_00_000_1000_00_0);
        cyc("ld_mem3", 0, 0, 0, 0, 16'b00_01_00_000_1000_00_0);
        cyc("ld_mem4", 0, 0, 1, 0, 16'b00_01_00_000_1000_00_0);
        cyc("ld_wb", 0, 0, 0, 0, 16'b00_01_00_000_0011_10_0);

        cyc("cbz_t_fetch", I_CBZ, 1, 0, 1, V_LOAD);
        cyc("cbz_t_decode", 0, 0, 0, 1, V_NONE);
        cyc("cbz_t_exec", 0, 0, 0, 1, 16'b00_00_01_010_0000_11_0);
        cyc("cbz_n_fetch", I_CBZ, 1, 0, 0, V_LOAD);
        cyc("cbz_n_decode", 0, 0, 0, 0, V_NONE);
        cyc("cbz_n_exec", 0, 0, 0, 0, 16'b00_00_01_010_0000_10_0);

        cyc("cbnz_fetch", I_CBNZ, 1, 0, 0, V_LOAD);
        cyc("cbnz_decode", 0, 0, 0, 0, V_NONE);
        cyc("cbnz_exec", 0, 0, 0, 0, 16'b00_00_01_001_0000_11_0);
        cyc("b_fetch", I_B, 1, 0, 1, V_LOAD);
        cyc("b_decode", 0, 0, 0, 1, V_NONE);
        cyc("b_exec", 0, 0, 0, 1, 16'b00_00_01_100_0000_11_0);

        cyc("addi_fetch", I_ADDI, 1, 0, 0, V_LOAD);
        cyc("addi_decode", 0, 0, 0, 0, V_NONE);
        cyc("addi_exec", 0, 0, 0, 0, 16'b00_10_10_000_0000_00_0);
        cyc("addi_wb", 0, 0, 0, 0, 16'b00_10_10_000_0001_10_0);
        cyc("movz_fetch", I_MOVZ, 1, 0, 0, V_LOAD);
        cyc("movz_decode", 0, 0, 0, 0, V_NONE);
        cyc("movz_exec", 0, 0, 0, 0, 16'b00_01_10_000_0000_00_0);
        cyc("movz_wb", 0, 0, 0, 0, 16'b00_01_10_000_0001_10_0);

        cyc("st_fetch", I_STUR, 1, 0, 0, V_LOAD);
        cyc("st_decode", 0, 0, 0, 0, V_NONE);
        cyc("st_exec", 0, 0, 0, 0, 16'b00_01_00_000_0000_00_0);
        cyc("st_mem_done", 0, 0, 1, 0, 16'b00_01_00_000_0100_10_0);
        cyc("st_after", 0, 0, 0, 0, V_IDLE);

        cyc("st2_fetch", I_STUR, 1, 0, 0, V_LOAD);
        cyc("st2_decode", 0, 0, 0, 0, V_NONE);
        cyc("st2_exec", 0, 0, 0, 0, 16'b00_01_00_000_0000_00_0);
        cyc("st2_mem", 0, 0, 0, 0, 16'b00_01_00_000_0100_00_0);
        rst_n = 1'b0;
        #1;
        chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rst_vec", {16'h0, vec}, {16'h0, V_IDLE});
        chk("rst_ir", instr_q, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rel_vec", {16'h0, vec}, {16'h0, V_IDLE});
        @(posedge clk);
        #1;

        for (int k = 0; k < 3; k++) begin
            cyc("perf_fetch", I_ADD, 1, 0, 0, V_LOAD);
            cyc("perf_decode", 0, 0, 0, 0, V_NONE);
            cyc("perf_exec", 0, 0, 0, 0, 16'b00_00_10_000_0000_00_0);
            cyc("perf_wb", 0, 0, 0, 0, 16'b00_00_10_000_0001_10_0);
        end
`ifdef EXEC_SEQ_PERF_EN
        chk("perf_cycles", cycle_cnt, 32'd13);
        chk("perf_retired", retired_cnt, 32'd3);
`endif

        cyc("trap_fetch", I_BAD, 1, 0, 0, V_LOAD);
        cyc("trap_decode", 0, 0, 0, 0, V_NONE);
        for (int k = 0; k < 10; k++)
            cyc("trap_hold", I_ADD, k[0], 1, 0, 16'b00_00_00_000_0000_00_1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
